// File: rtl/rvvi_depacketizer_pkg.sv
// Shared types and sizing for the RVVI trace depacketizer.
package rvvi_depacketizer_pkg;

  typedef struct packed {
    int XLEN;
  } cvw_t;

  localparam cvw_t RVVI_CVW_DEFAULT = '{XLEN: 64};
  localparam int HDR_WORDS = 4;
  localparam logic [15:0] RVVI_ETHERTYPE = 16'h88B5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_DROP,
    S_OUT
  } state_t;

  function automatic int rvvi_w(input int xlen, input int max_csrs);
    return 72 + 5 * xlen + max_csrs * (xlen + 16);
  endfunction

endpackage

// File: rtl/rvvi_satcounter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module rvvi_satcounter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'h0000;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/rvvi_depacketizer.sv
// Reassembles one RVVI trace vector per Ethernet frame from a 32-bit AXI-stream; malformed frames are dropped and counted.
// Optional RVVI_SEQ_CHECK_EN adds a sequence-continuity check feeding SeqErrCount.
module rvvi_depacketizer
  import rvvi_depacketizer_pkg::*;
#(
  parameter cvw_t        P         = RVVI_CVW_DEFAULT,
  parameter int          MAX_CSRS  = 5,
  parameter logic [15:0] ETHERTYPE = RVVI_ETHERTYPE
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [31:0]                            rx_axis_tdata,
  input  logic [3:0]                             rx_axis_tkeep,
  input  logic                                   rx_axis_tvalid,
  output logic                                   rx_axis_tready,
  input  logic                                   rx_axis_tlast,
  input  logic                                   rx_axis_tuser,
  output logic                                   RvviValid,
  input  logic                                   RvviReady,
  output logic [rvvi_w(P.XLEN, MAX_CSRS)-1:0]    Rvvi,
  output logic [15:0]                            DropCount,
  output logic [15:0]                            SeqErrCount
);

  localparam int RVVI_W = rvvi_w(P.XLEN, MAX_CSRS);
  localparam int PW     = (RVVI_W + 31) / 32;
  localparam int LASTW  = RVVI_W - 32 * (PW - 1);
  localparam int CW     = $clog2(PW + HDR_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(PW - 1);
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_WORDS - 1);

  state_t              state;
  logic [CW-1:0]       wcnt;
  logic [RVVI_W-1:0]   rvvi_q;
  logic                beat;
  logic                type_ok;
  logic                good_end;
  logic                to_out;
  logic                drop;
  logic                seq_err;

  assign rx_axis_tready = (state != S_OUT);
  assign beat           = rx_axis_tvalid && rx_axis_tready;
  // EtherType occupies bytes 12-13 of the header, sent most-significant byte first.
  assign type_ok        = {rx_axis_tdata[7:0], rx_axis_tdata[15:8]} == ETHERTYPE;
  assign good_end       = !rx_axis_tuser && (|rx_axis_tkeep);
  assign to_out         = (state == S_PAY) && beat && (wcnt == LAST_IDX) && rx_axis_tlast && good_end;
  assign Rvvi           = rvvi_q;

  always_comb begin
    drop = 1'b0;
    if (beat) begin
      case (state)
        S_IDLE:  drop = rx_axis_tlast;
        S_HDR:   drop = rx_axis_tlast || (wcnt == HDR_LAST && !type_ok);
        S_PAY:   drop = (wcnt == LAST_IDX) ? !(rx_axis_tlast && good_end) : rx_axis_tlast;
        default: drop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      rvvi_q    <= '0;
      RvviValid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat && !rx_axis_tlast) begin
            state <= S_HDR;
            wcnt  <= CW'(1);
          end
        end
        S_HDR: begin
          if (beat) begin
            if (rx_axis_tlast) begin
              state <= S_IDLE;
            end else if (wcnt == HDR_LAST) begin
              state <= type_ok ? S_PAY : S_DROP;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        S_PAY: begin
          if (beat) begin
            for (int k = 0; k < PW - 1; k++) begin
              if (wcnt == CW'(k)) rvvi_q[32*k +: 32] <= rx_axis_tdata;
            end
            // Padding bits of the final word beyond RVVI_W are discarded.
            if (wcnt == LAST_IDX) rvvi_q[RVVI_W-1 -: LASTW] <= rx_axis_tdata[LASTW-1:0];
            if (wcnt == LAST_IDX) begin
              if (!rx_axis_tlast) begin
                state <= S_DROP;
              end else if (good_end) begin
                state     <= S_OUT;
                RvviValid <= 1'b1;
              end else begin
                state <= S_IDLE;
              end
            end else if (rx_axis_tlast) begin
              state <= S_IDLE;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
        end
        S_DROP: begin
          if (beat && rx_axis_tlast) state <= S_IDLE;
        end
        S_OUT: begin
          if (RvviReady) begin
            state     <= S_IDLE;
            RvviValid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RVVI_SEQ_CHECK_EN
  logic [15:0] seq_cur;
  logic [15:0] seq_exp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cur <= 16'h0000;
      seq_exp <= 16'h0000;
    end else begin
      if (state == S_HDR && beat && wcnt == HDR_LAST)
        seq_cur <= {rx_axis_tdata[23:16], rx_axis_tdata[31:24]};
      if (to_out) seq_exp <= seq_cur + 16'h0001;
    end
  end

  assign seq_err = to_out && (seq_cur != seq_exp);
`else
  assign seq_err = 1'b0;
`endif

  rvvi_satcounter u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (drop),
    .count (DropCount)
  );

  rvvi_satcounter u_seq_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (seq_err),
    .count (SeqErrCount)
  );

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer at XLEN=64, MAX_CSRS=5 (792-bit vector, 25 payload words).
module tb_rvvi_depacketizer;
  import rvvi_depacketizer_pkg::*;

  localparam cvw_t TB_P = '{XLEN: 64};
  localparam int RW = 792;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   rx_axis_tdata;
  logic [3:0]    rx_axis_tkeep;
  logic          rx_axis_tvalid;
  logic          rx_axis_tready;
  logic          rx_axis_tlast;
  logic          rx_axis_tuser;
  logic          RvviValid;
  logic          RvviReady;
  logic [RW-1:0] Rvvi;
  logic [15:0]   DropCount;
  logic [15:0]   SeqErrCount;

  int checks = 0;
  int failures = 0;
  bit gap = 1'b0;

  rvvi_depacketizer #(.P(TB_P), .MAX_CSRS(5), .ETHERTYPE(16'h88B5)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tkeep  (rx_axis_tkeep),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tready (rx_axis_tready),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tuser  (rx_axis_tuser),
    .RvviValid      (RvviValid),
    .RvviReady      (RvviReady),
    .Rvvi           (Rvvi),
    .DropCount      (DropCount),
    .SeqErrCount    (SeqErrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic l, input logic u, input logic [3:0] k);
    int n;
    if (gap) begin
      rx_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    rx_axis_tdata  = d;
    rx_axis_tlast  = l;
    rx_axis_tuser  = u;
    rx_axis_tkeep  = k;
    rx_axis_tvalid = 1'b1;
    n = 0;
    while (!rx_axis_tready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_axis_tready) begin
      checks++;
      failures++;
      $error("FAIL beat_timeout: observed tready=0 expected tready=1");
    end
    @(posedge clk); #1;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
  endtask

  function automatic logic [31:0] hdr3(input logic [15:0] et, input logic [15:0] seq);
    return {seq[7:0], seq[15:8], et[7:0], et[15:8]};
  endfunction

  // Payload word k carries base+k; last beat gets tlast plus the given tuser/tkeep.
  task automatic frame(input logic [15:0] et, input logic [15:0] seq, input int base,
                       input int npay, input logic u, input logic [3:0] klast);
    put(32'hFFFF_FFFF, 1'b0, 1'b0, 4'hF);
    put(32'h3322_11FF, 1'b0, 1'b0, 4'hF);
    put(32'h7766_5544, 1'b0, 1'b0, 4'hF);
    put(hdr3(et, seq), 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < npay; k++) begin
      if (k == npay - 1) put(32'(base + k), 1'b1, u, klast);
      else               put(32'(base + k), 1'b0, 1'b0, 4'hF);
    end
  endtask

  task automatic release_vec(input string tag);
    RvviReady = 1'b1;
    @(posedge clk); #1;
    RvviReady = 1'b0;
    chk({tag, "_valid_fall"}, 64'(RvviValid), 64'd0);
    chk({tag, "_tready_back"}, 64'(rx_axis_tready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    rx_axis_tdata = '0; rx_axis_tkeep = 4'hF; rx_axis_tvalid = 1'b0;
    rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0; RvviReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(RvviValid), 64'd0);
    chk("rst_rvvi_lo", Rvvi[63:0], 64'd0);
    chk("rst_rvvi_hi", 64'(Rvvi[791:768]), 64'd0);
    chk("rst_drop", 64'(DropCount), 64'd0);
    chk("rst_seqerr", 64'(SeqErrCount), 64'd0);
    chk("rst_tready", 64'(rx_axis_tready), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Good frame, seq 0
    frame(16'h88B5, 16'd0, 0, 25, 1'b0, 4'hF);
    chk("a_valid_rise", 64'(RvviValid), 64'd1);
    chk("a_tready_low", 64'(rx_axis_tready), 64'd0);
    chk("a_w0", 64'(Rvvi[31:0]), 64'd0);
    chk("a_w1", 64'(Rvvi[63:32]), 64'd1);
    chk("a_w13", 64'(Rvvi[447:416]), 64'd13);
    chk("a_w24", 64'(Rvvi[791:768]), 64'd24);

    // Back-pressure: next header beat waits while the vector is held
    rx_axis_tdata = 32'hFFFF_FFFF; rx_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_tready", 64'(rx_axis_tready), 64'd0);
      chk("bp_valid", 64'(RvviValid), 64'd1);
      chk("bp_w1", 64'(Rvvi[63:32]), 64'd1);
    end
    rx_axis_tvalid = 1'b0;
    release_vec("a");

    frame(16'h88B5, 16'd1, 100, 25, 1'b0, 4'hF);
    chk("b_valid", 64'(RvviValid), 64'd1);
    chk("b_w0", 64'(Rvvi[31:0]), 64'd100);
    chk("b_w1", 64'(Rvvi[63:32]), 64'd101);
    chk("b_w24", 64'(Rvvi[791:768]), 64'd124);
    release_vec("b");

    // Wrong EtherType: dropped at header word 3, payload untouched
    frame(16'h0800, 16'd9, 0, 25, 1'b0, 4'hF);
    chk("et_valid", 64'(RvviValid), 64'd0);
    chk("et_drop", 64'(DropCount), 64'd1);
    chk("et_hold_w1", 64'(Rvvi[63:32]), 64'd101);

    // Runt: tlast on payload word 10, then a good frame with seq 3
    frame(16'h88B5, 16'd9, 200, 11, 1'b0, 4'hF);
    chk("runt_valid", 64'(RvviValid), 64'd0);
    chk("runt_drop", 64'(DropCount), 64'd2);
    frame(16'h88B5, 16'd3, 300, 25, 1'b0, 4'hF);
    chk("c_valid", 64'(RvviValid), 64'd1);
    chk("c_w0", 64'(Rvvi[31:0]), 64'd300);
    chk("c_w1", 64'(Rvvi[63:32]), 64'd301);
    chk("c_w24", 64'(Rvvi[791:768]), 64'd324);
    chk("c_drop", 64'(DropCount), 64'd2);
`ifdef RVVI_SEQ_CHECK_EN
    chk("c_seqerr", 64'(SeqErrCount), 64'd1);
`else
    chk("c_seqerr", 64'(SeqErrCount), 64'd0);
`endif
    release_vec("c");

    // Too long, bad tuser, empty tkeep on the last beat
    frame(16'h88B5, 16'd4, 0, 26, 1'b0, 4'hF);
    chk("long_valid", 64'(RvviValid), 64'd0);
    chk("long_drop", 64'(DropCount), 64'd3);
    chk("long_tready", 64'(rx_axis_tready), 64'd1);
    frame(16'h88B5, 16'd4, 0, 25, 1'b1, 4'hF);
    chk("tuser_valid", 64'(RvviValid), 64'd0);
    chk("tuser_drop", 64'(DropCount), 64'd4);
    frame(16'h88B5, 16'd4, 0, 25, 1'b0, 4'h0);
    chk("tkeep_valid", 64'(RvviValid), 64'd0);
    chk("tkeep_drop", 64'(DropCount), 64'd5);

    // tvalid gaps between every beat
    gap = 1'b1;
    frame(16'h88B5, 16'd4, 400, 25, 1'b0, 4'hF);
    gap = 1'b0;
    chk("gap_valid", 64'(RvviValid), 64'd1);
    chk("gap_w1", 64'(Rvvi[63:32]), 64'd401);
    chk("gap_w24", 64'(Rvvi[791:768]), 64'd424);
`ifdef RVVI_SEQ_CHECK_EN
    chk("gap_seqerr", 64'(SeqErrCount), 64'd1);
`else
    chk("gap_seqerr", 64'(SeqErrCount), 64'd0);
`endif
    release_vec("gap");

    // Reset mid-payload; the tail then arrives as one headerless frame
    put(32'hFFFF_FFFF, 1'b0, 1'b0, 4'hF);
    put(32'h3322_11FF, 1'b0, 1'b0, 4'hF);
    put(32'h7766_5544, 1'b0, 1'b0, 4'hF);
    put(hdr3(16'h88B5, 16'd5), 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 5; k++) put(32'(500 + k), 1'b0, 1'b0, 4'hF);
    reset = 1'b1;
    #1;
    chk("mrst_valid", 64'(RvviValid), 64'd0);
    chk("mrst_drop", 64'(DropCount), 64'd0);
    chk("mrst_w0", 64'(Rvvi[31:0]), 64'd0);
    chk("mrst_tready", 64'(rx_axis_tready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 5; k < 25; k++) put(32'(500 + k), k == 24, 1'b0, 4'hF);
    chk("tail_valid", 64'(RvviValid), 64'd0);
    chk("tail_drop", 64'(DropCount), 64'd1);
    frame(16'h88B5, 16'd0, 600, 25, 1'b0, 4'hF);
    chk("d_valid", 64'(RvviValid), 64'd1);
    chk("d_w1", 64'(Rvvi[63:32]), 64'd601);
    chk("d_seqerr", 64'(SeqErrCount), 64'd0);
    release_vec("d");

    // Back-to-back single-beat runts drive DropCount into saturation
    rx_axis_tdata = 32'h0; rx_axis_tlast = 1'b1; rx_axis_tuser = 1'b0; rx_axis_tvalid = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_fffe", 64'(DropCount), 64'hFFFE);
    @(posedge clk); #1;
    chk("sat_ffff", 64'(DropCount), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 64'(DropCount), 64'hFFFF);
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
    chk("sat_valid", 64'(RvviValid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
